// File: rtl/affine_tap_accumulator.sv
// affine_tap_accumulator: signs and accumulates the selected MCM product per tap,
// then rounds, shifts and clips the packet sum into an unsigned output sample.
module affine_tap_accumulator #(
   parameter int NTAPS = 6,
   parameter int IN_W  = 16,
   parameter int ACC_W = 20,
   parameter int SHIFT = 4,
   parameter int OUT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_first,
   input  logic                    in_last,
   input  logic [2:0]              in_coef_mag,
   input  logic                    in_coef_neg,
   input  logic signed [IN_W-1:0]  y1,
   input  logic signed [IN_W-1:0]  y2,
   input  logic signed [IN_W-1:0]  y3,
   input  logic signed [IN_W-1:0]  y4,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUT_W-1:0]        out_data,
   output logic [ACC_W-1:0]        out_raw,
   output logic                    out_err
);
   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
   state_t                  r_state, w_state_nxt;
   logic signed [ACC_W-1:0] r_acc, w_acc_nxt, w_sel, w_term, w_rnd, w_shr;
   logic [2:0]              r_cnt, w_cnt_nxt;
   logic                    r_err, w_err_nxt, w_take, w_bad, w_load;
   logic [OUT_W-1:0]        r_data, w_clip;
   logic [ACC_W-1:0]        r_raw;
   logic                    r_oerr;

   assign out_valid = r_state == HOLD;
   assign in_ready  = !out_valid;
   assign out_data  = r_data;
   assign out_raw   = r_raw;
   assign out_err   = r_oerr;
   assign w_take    = in_valid & in_ready;
   assign w_bad     = in_coef_mag > 3'd4;

   always_comb begin
      w_sel = in_coef_mag == 3'd1 ? ACC_W'(y1) :
              in_coef_mag == 3'd2 ? ACC_W'(y2) :
              in_coef_mag == 3'd3 ? ACC_W'(y3) :
              in_coef_mag == 3'd4 ? ACC_W'(y4) : '0;
      w_term = in_coef_neg ? -w_sel : w_sel;
   end

   // in_first always restarts a packet; reaching it from ACCUM marks the new packet bad
   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = r_err;
      w_load      = 1'b0;
      if (w_take && (in_first || r_state == ACCUM)) begin
         w_acc_nxt   = in_first ? w_term : r_acc + w_term;
         w_cnt_nxt   = in_first ? 3'd1 : r_cnt + 3'(r_cnt != 3'd7);
         w_err_nxt   = w_bad | (in_first ? r_state == ACCUM : r_err);
         w_state_nxt = in_last ? HOLD : ACCUM;
         w_load      = in_last;
      end else if (r_state == HOLD && out_ready) begin
         w_state_nxt = IDLE;
      end
   end

   always_comb begin
      w_rnd  = w_acc_nxt + ACC_W'(1 << (SHIFT - 1));
      w_shr  = w_rnd >>> SHIFT;
      w_clip = w_shr[ACC_W-1] ? '0 : |w_shr[ACC_W-1:OUT_W] ? '1 : w_shr[OUT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_data  <= '0;
         r_raw   <= '0;
         r_oerr  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_cnt   <= w_cnt_nxt;
         r_err   <= w_err_nxt;
         if (w_load) begin
            r_data <= w_clip;
            r_raw  <= w_acc_nxt;
            r_oerr <= w_err_nxt | (w_cnt_nxt != 3'(NTAPS));
         end
      end
   end
endmodule
